// File: rtl/ddr4_cmd_gen.sv
// ----------------------------------------------------------------------------
// ddr4_cmd_gen
//
// Single-rank DDR4 command generator. One read/write request is accepted at a
// time. The request is classified against an open-row table (one entry per
// bankgroup/bank) and turned into the minimal PRE / ACT / CAS sequence. Each
// command occupies one clock with cs_n low; every other cycle is a deselect.
// TRP, TRCD and TCCD spacings are enforced by one shared down-counter.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE with cke high)
//   req_write             1 = WRITE, 0 = READ
//   req_bg/req_ba         target bankgroup / bank
//   req_row/req_col       target row / column
//   act_n, A, bg, ba      DDR4 command/address bus (registered)
//   cs_n, cke             chip select, clock enable (registered)
//   rd_issued/wr_issued   one-cycle pulse while READ/WRITE is on the bus
// ----------------------------------------------------------------------------
module ddr4_cmd_gen #(
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int ADDRWIDTH = 17,
    parameter int COLWIDTH  = 10,
    parameter int TRCD      = 3,
    parameter int TRP       = 3,
    parameter int TCCD      = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [BGWIDTH-1:0]   req_bg,
    input  logic [BAWIDTH-1:0]   req_ba,
    input  logic [ADDRWIDTH-1:0] req_row,
    input  logic [COLWIDTH-1:0]  req_col,
    output logic                 act_n,
    output logic [ADDRWIDTH-1:0] A,
    output logic [BGWIDTH-1:0]   bg,
    output logic [BAWIDTH-1:0]   ba,
    output logic                 cs_n,
    output logic                 cke,
    output logic                 rd_issued,
    output logic                 wr_issued
);

    localparam int BIDW  = BGWIDTH + BAWIDTH;
    localparam int NBANK = 1 << BIDW;
    localparam int TMAX  = (TRCD > TRP) ? ((TRCD > TCCD) ? TRCD : TCCD)
                                        : ((TRP  > TCCD) ? TRP  : TCCD);
    localparam int CNTW  = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_WAIT_RP,
        S_ACT,
        S_WAIT_RCD,
        S_CAS,
        S_WAIT_CCD
    } state_t;

    state_t                state_q, state_d;
    logic [CNTW-1:0]       cnt_q, cnt_d;

    // Captured request
    logic                  rq_write_q;
    logic [BGWIDTH-1:0]    rq_bg_q;
    logic [BAWIDTH-1:0]    rq_ba_q;
    logic [ADDRWIDTH-1:0]  rq_row_q;
    logic [COLWIDTH-1:0]   rq_col_q;

    // Open-row table
    logic [NBANK-1:0]      open_vld_q;
    logic [ADDRWIDTH-1:0]  open_row_q [NBANK];

    // Registered bus
    logic                  cs_n_q, cs_n_d;
    logic                  act_n_q, act_n_d;
    logic [ADDRWIDTH-1:0]  a_q, a_d;
    logic [BGWIDTH-1:0]    bg_q, bg_d;
    logic [BAWIDTH-1:0]    ba_q, ba_d;
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic                  cke_q;
    logic                  ready_q, ready_d;

    logic                  accept;
    logic                  cur_write;
    logic [BGWIDTH-1:0]    cur_bg;
    logic [BAWIDTH-1:0]    cur_ba;
    logic [ADDRWIDTH-1:0]  cur_row;
    logic [COLWIDTH-1:0]   cur_col;
    logic [BIDW-1:0]       cur_idx;

    assign accept = req_valid && ready_q;

    // On the acceptance edge the request is not yet in the capture registers,
    // so the first command is built straight from the inputs.
    assign cur_write = accept ? req_write : rq_write_q;
    assign cur_bg    = accept ? req_bg    : rq_bg_q;
    assign cur_ba    = accept ? req_ba    : rq_ba_q;
    assign cur_row   = accept ? req_row   : rq_row_q;
    assign cur_col   = accept ? req_col   : rq_col_q;
    assign cur_idx   = {cur_bg, cur_ba};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // Wait counters are loaded with T-2: the command cycle and the final
    // zero-count cycle together account for the other two cycles.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!open_vld_q[cur_idx]) begin
                        state_d = S_ACT;
                    end else if (open_row_q[cur_idx] == cur_row) begin
                        state_d = S_CAS;
                    end else begin
                        state_d = S_PRE;
                    end
                end
            end
            S_PRE: begin
                state_d = S_WAIT_RP;
                cnt_d   = CNTW'(TRP - 2);
            end
            S_WAIT_RP: begin
                if (cnt_q == '0) state_d = S_ACT;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_ACT: begin
                state_d = S_WAIT_RCD;
                cnt_d   = CNTW'(TRCD - 2);
            end
            S_WAIT_RCD: begin
                if (cnt_q == '0) state_d = S_CAS;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_CAS: begin
                state_d = S_WAIT_CCD;
                cnt_d   = CNTW'(TCCD - 2);
            end
            S_WAIT_CCD: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: the bus for the coming cycle is derived from the state
    // being entered, then registered, so the bus always matches state_q.
    // A16/A15/A14 carry RAS_n/CAS_n/WE_n when act_n is high; A10 stays 0
    // (no auto-precharge, single-bank precharge).
    // ------------------------------------------------------------------
    always_comb begin
        cs_n_d  = 1'b1;
        act_n_d = 1'b1;
        a_d     = '0;
        bg_d    = '0;
        ba_d    = '0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        ready_d = (state_d == S_IDLE) && cke_q;
        unique case (state_d)
            S_PRE: begin
                cs_n_d = 1'b0;
                a_d[15] = 1'b1;
                bg_d   = cur_bg;
                ba_d   = cur_ba;
            end
            S_ACT: begin
                cs_n_d  = 1'b0;
                act_n_d = 1'b0;
                a_d     = cur_row;
                bg_d    = cur_bg;
                ba_d    = cur_ba;
            end
            S_CAS: begin
                cs_n_d              = 1'b0;
                a_d[16]             = 1'b1;
                a_d[14]             = ~cur_write;
                a_d[COLWIDTH-1:0]   = cur_col;
                bg_d                = cur_bg;
                ba_d                = cur_ba;
                rd_d                = ~cur_write;
                wr_d                = cur_write;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_n_q  <= 1'b1;
            act_n_q <= 1'b1;
            a_q     <= '0;
            bg_q    <= '0;
            ba_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            cke_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            cs_n_q  <= cs_n_d;
            act_n_q <= act_n_d;
            a_q     <= a_d;
            bg_q    <= bg_d;
            ba_q    <= ba_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cke_q   <= 1'b1;
            ready_q <= ready_d;
        end
    end

    // Request capture; only the handshake edge loads, later input
    // changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            rq_write_q <= req_write;
            rq_bg_q    <= req_bg;
            rq_ba_q    <= req_ba;
            rq_row_q   <= req_row;
            rq_col_q   <= req_col;
        end
    end

    // Open-row table: valid bits are cleared by reset, row payload is
    // meaningless while its valid bit is low and needs no reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            open_vld_q <= '0;
        end else if (state_d == S_ACT) begin
            open_vld_q[cur_idx] <= 1'b1;
        end else if (state_d == S_PRE) begin
            open_vld_q[cur_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (state_d == S_ACT) begin
            open_row_q[cur_idx] <= cur_row;
        end
    end

    assign req_ready = ready_q;
    assign cs_n      = cs_n_q;
    assign act_n     = act_n_q;
    assign A         = a_q;
    assign bg        = bg_q;
    assign ba        = ba_q;
    assign cke       = cke_q;
    assign rd_issued = rd_q;
    assign wr_issued = wr_q;

endmodule
